// File: rtl/mac_pkg.sv
//------------------------------------------------------------------------------
// mac_pkg : shared widths, operand/product types and feeder state encoding
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mac_pkg;

  localparam int AW     = 8;
  localparam int BW     = 11;
  localparam int DATAW  = AW + BW;
  localparam int ACCUMW = 32;
  localparam int LENW   = 10;

  typedef logic signed [AW-1:0]    act_t;
  typedef logic signed [BW-1:0]    wgt_t;
  typedef logic signed [DATAW-1:0] prod_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } feed_state_e;

endpackage

`default_nettype wire

// File: rtl/mac_mul_pipe.sv
//------------------------------------------------------------------------------
// mac_mul_pipe : 2-stage full-precision signed multiply with valid/first/last
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mac_mul_pipe #(
  parameter int AW    = 8,
  parameter int BW    = 11,
  parameter int DATAW = 19
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [AW-1:0]    a,
  input  logic signed [BW-1:0]    b,
  input  logic                    in_first,
  input  logic                    in_last,
  output logic                    s1_valid,
  output logic                    out_valid,
  output logic signed [DATAW-1:0] out_data,
  output logic                    out_first,
  output logic                    out_last
);

  import mac_pkg::*;

  logic signed [AW-1:0]    r_s1_a;
  logic signed [BW-1:0]    r_s1_b;
  logic                    r_s1_valid;
  logic                    r_s1_first;
  logic                    r_s1_last;
  logic                    r_s2_valid;
  logic signed [DATAW-1:0] r_s2_data;
  logic                    r_s2_first;
  logic                    r_s2_last;

  logic signed [DATAW-1:0] w_a_ext;
  logic signed [DATAW-1:0] w_b_ext;
  logic signed [DATAW-1:0] w_prod;

  // Extend both operands to the product width so the -min*-min corner is exact.
  assign w_a_ext = r_s1_a;
  assign w_b_ext = r_s1_b;
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      if (in_valid) begin
        r_s1_a <= a;
        r_s1_b <= b;
      end
      r_s1_valid <= in_valid;
      r_s1_first <= in_valid & in_first;
      r_s1_last  <= in_valid & in_last;
    end
  end

  // Bubbles leave stage 2 as all-zero so downstream sees clean idle outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_data  <= r_s1_valid ? w_prod : '0;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
    end
  end

  assign s1_valid  = r_s1_valid;
  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_first = r_s2_first;
  assign out_last  = r_s2_last;

endmodule

`default_nettype wire

// File: rtl/mac_feeder.sv
//------------------------------------------------------------------------------
// mac_feeder : operand-pair feeder for accum; vector FSM, tagging, multiply.
// Optional MAC_FEEDER_PERF_EN adds the stall_cnt output.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mac_feeder #(
  parameter int AW    = 8,
  parameter int BW    = 11,
  parameter int DATAW = 19,
  parameter int LENW  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LENW-1:0]         len,
  input  logic signed [AW-1:0]    a_data,
  input  logic signed [BW-1:0]    b_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [DATAW-1:0] data,
  output logic                    ivalid,
  output logic                    first,
  output logic                    last,
  output logic                    busy,
  output logic                    len_err
`ifdef MAC_FEEDER_PERF_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  import mac_pkg::*;

  if (DATAW != AW + BW) begin : g_width_chk
    $error("mac_feeder: DATAW must equal AW+BW");
  end

  feed_state_e     r_state;
  feed_state_e     w_next;
  logic [LENW-1:0] r_len_q;
  logic [LENW-1:0] r_count;
  logic            r_len_err;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_start_ok;
  logic            w_first_tag;
  logic            w_last_tag;
  logic            w_s1_valid;

  assign w_accept    = w_in_ready & in_valid;
  assign w_start_ok  = (r_state == IDLE) & start & (len != '0);
  assign w_first_tag = (r_count == '0);
  assign w_last_tag  = (r_count == r_len_q - LENW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_start_ok) w_next = RUN;
      RUN:     if (w_accept && w_last_tag) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready = 1'b0;
    if (r_state == RUN) w_in_ready = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len_q   <= '0;
      r_count   <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= (r_state == IDLE) & start & (len == '0);
      if (w_start_ok) begin
        r_len_q <= len;
        r_count <= '0;
      end else if (w_accept) begin
        r_count <= w_last_tag ? '0 : r_count + LENW'(1);
      end
    end
  end

  mac_mul_pipe #(
    .AW    (AW),
    .BW    (BW),
    .DATAW (DATAW)
  ) u_mul_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_accept),
    .a         (a_data),
    .b         (b_data),
    .in_first  (w_first_tag),
    .in_last   (w_last_tag),
    .s1_valid  (w_s1_valid),
    .out_valid (ivalid),
    .out_data  (data),
    .out_first (first),
    .out_last  (last)
  );

  assign in_ready = w_in_ready;
  assign len_err  = r_len_err;
  assign busy     = w_in_ready | w_s1_valid | ivalid;

`ifdef MAC_FEEDER_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_stall_cnt <= '0;
    else if (w_start_ok)
      r_stall_cnt <= '0;
    else if ((r_state == RUN) && !in_valid && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire
